fc_l2_port_arbiter: RTL and testbench
=====================================

// Module: fc_l2_port_arbiter
// PURPOSE
//  Shares one L2 TCDM-style master port between N_REQ in-order requesters (FC core data port + FC HWPE ports)
//  when the SoC is built with fewer L2 interconnect ports than FC masters. Grant: round-robin, with optional
//  strict priority for requester 0 (core). In-order ID FIFO routes each response to the requester that issued it.
// PARAMETERS
//  N_REQ      4   number of requesters, >=2; index 0 is the core data port
//  ADDR_W     32  address width
//  DATA_W     32  data width; BE width = DATA_W/8
//  MAX_OUTST  4   max granted-but-unanswered transactions, power of 2, >=1
//  CORE_PRIO  0   1: requester 0 strictly wins over others; 0: pure round-robin
// PORTS
//  clk_i          in   1               clock
//  rst_i          in   1               synchronous reset, active-high
//  s_req_i        in   N_REQ           per-requester request
//  s_add_i        in   N_REQ*ADDR_W    per-requester address
//  s_wen_i        in   N_REQ           per-requester write-enable, active-low (1 = read)
//  s_wdata_i      in   N_REQ*DATA_W    per-requester write data
//  s_be_i         in   N_REQ*DATA_W/8  per-requester byte enables
//  s_gnt_o        out  N_REQ           one-hot grant
//  s_r_valid_o    out  N_REQ           one-hot response valid
//  s_r_rdata_o    out  DATA_W          response data, shared by all requesters
//  s_r_opc_o      out  1               response error, shared; qualified by s_r_valid_o
//  m_req_o        out  1               master request
//  m_add_o        out  ADDR_W          master address
//  m_wen_o        out  1               master write-enable, active-low
//  m_wdata_o      out  DATA_W          master write data
//  m_be_o         out  DATA_W/8        master byte enables
//  m_gnt_i        in   1               master grant
//  m_r_valid_i    in   1               master response valid
//  m_r_rdata_i    in   DATA_W          master response data
//  m_r_opc_i      in   1               master response error
//  outst_o        out  clog2(MAX_OUTST)+1  outstanding transaction count
//  spurious_o     out  1               1-cycle pulse: m_r_valid_i received with no outstanding transaction
// BEHAVIOUR
//  - Reset (rst_i=1 at clk edge): RR pointer=0, FIFO empty, outst_o=0.
//  - While rst_i=1: m_req_o=0, s_gnt_o=0, s_r_valid_o=0, spurious_o=0, overriding all inputs.
//  - Arbitration is combinational, in the same cycle.
//    - Winner = first requester with s_req_i set, scanning from RR pointer upward and wrapping.
//    - CORE_PRIO=1: requester 0 wins whenever s_req_i[0]=1.
//    - m_req_o = |s_req_i && !fifo_full.
//    - m_add/wen/wdata/be_o = winner's fields when m_req_o=1; '0 otherwise.
//    - s_gnt_o[winner] = m_gnt_i && m_req_o; all other grants are 0.
//  - Handshake (m_req_o && m_gnt_i):
//    - winner index is pushed into the ID FIFO;
//    - RR pointer <= (winner+1) mod N_REQ on the next edge;
//    - pointer holds when there is no handshake.
//  - Response: master responses are in order, at least 1 cycle after their grant.
//    - On m_r_valid_i with FIFO not empty: s_r_valid_o[fifo_head]=1 in the same cycle (zero latency), then pop.
//    - s_r_rdata_o/s_r_opc_o = m_r_rdata_i/m_r_opc_i, driven unconditionally.
//  - Full: at outst==MAX_OUTST, m_req_o=0 and no grants. Full->not-full on a pop takes effect next cycle.
//  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
//  - m_r_valid_i with FIFO empty: s_r_valid_o stays 0, spurious_o pulses, FIFO unchanged.
//    - Applies even if a push happens the same cycle, since a response cannot precede its grant.
//  - Requesters may drop s_req_i before a grant; no state is kept for ungranted requests.
//  - Reset mid-operation clears FIFO/pointer; late responses after reset raise spurious_o and are dropped.
//  - Width rules:
//    - outst_o counter has clog2(MAX_OUTST)+1 bits and never exceeds MAX_OUTST.
//    - FIFO pointers have clog2(MAX_OUTST) bits and wrap modulo MAX_OUTST.
// STRUCTURE
//  - fc_l2_arb_pkg: typedef req_t {add,wen,wdata,be} parameterised by localparams; function rr_pick(req,ptr,prio).
//  - Sub-module fc_l2_arb_id_fifo:
//    - holds MAX_OUTST entries of clog2(N_REQ) bits;
//    - push/pop/full/empty/count; synchronous active-high reset.
//  - Top level: arbiter comb logic, RR pointer register, response routing, spurious flag.
// TESTING
//  - Single requester 2 reads, m_gnt_i=1, r_valid 1 cycle later -> s_r_valid_o[2] pulses, rdata matches, outst 0->1->0.
//  - All 4 requesting, gnt always 1, CORE_PRIO=0 -> grant order 0,1,2,3,0 with responses routed 0,1,2,3,0.
//  - CORE_PRIO=1, s_req_i=4'b1111 held -> only requester 0 granted; drop req0 -> RR resumes among 1..3.
//  - Stall responses with MAX_OUTST=4, then 4 grants -> m_req_o=0, no s_gnt_o.
//    - One r_valid then frees a slot; 5th grant is issued next cycle.
//  - m_r_valid_i with outst=0 -> spurious_o=1 for 1 cycle, s_r_valid_o=0.
//  - rst_i asserted with 3 outstanding -> outst_o=0, pointer=0; later responses flag spurious_o.
//  - Constrained-random: all requests answered once, in order, and to the correct requester.

Source files
------------

// File: rtl/fc_l2_arb_pkg.sv
// ============================================================================
// Module      : fc_l2_arb_pkg
// Description : Shared widths, request record and round-robin pick function
//               for the FC L2 port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_l2_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Scan downward so the requester closest above ptr is the last (winning) write.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr,
                                               input logic             prio);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[IDX_W'(idx)]) pick = IDX_W'(idx);
    end
    if (prio && req[0]) pick = '0;
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_l2_port_arbiter_if.sv
// ============================================================================
// Module      : fc_l2_port_arbiter_if
// Description : Requester-side and L2-master-side bus bundle of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fc_l2_port_arbiter_if;
  import fc_l2_arb_pkg::*;

  logic [N_REQ-1:0]        s_req_i;
  logic [N_REQ*ADDR_W-1:0] s_add_i;
  logic [N_REQ-1:0]        s_wen_i;
  logic [N_REQ*DATA_W-1:0] s_wdata_i;
  logic [N_REQ*BE_W-1:0]   s_be_i;
  logic [N_REQ-1:0]        s_gnt_o;
  logic [N_REQ-1:0]        s_r_valid_o;
  logic [DATA_W-1:0]       s_r_rdata_o;
  logic                    s_r_opc_o;

  logic                    m_req_o;
  logic [ADDR_W-1:0]       m_add_o;
  logic                    m_wen_o;
  logic [DATA_W-1:0]       m_wdata_o;
  logic [BE_W-1:0]         m_be_o;
  logic                    m_gnt_i;
  logic                    m_r_valid_i;
  logic [DATA_W-1:0]       m_r_rdata_i;
  logic                    m_r_opc_i;

  // Arbiter view.
  modport master (
    input  s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
    output s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
    output m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
    input  m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i
  );

  // Environment view: requesters plus the L2 port.
  modport slave (
    output s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
    input  s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
    input  m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
    output m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i
  );

endinterface

`default_nettype wire

// File: rtl/fc_l2_arb_id_fifo.sv
// ============================================================================
// Module      : fc_l2_arb_id_fifo
// Description : In-order FIFO of granted requester indices awaiting response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_l2_arb_id_fifo #(
  parameter int MAX_OUTST = 4,
  parameter int ID_W      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_push,
  input  logic [ID_W-1:0]            i_id,
  input  logic                       i_pop,
  output logic [ID_W-1:0]            o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(MAX_OUTST):0] o_count
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [PTR_W-1:0] c_last = PTR_W'(MAX_OUTST - 1);

  logic [ID_W-1:0]  r_mem [MAX_OUTST];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(MAX_OUTST));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_id;
        r_wptr        <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fc_l2_port_arbiter.sv
// ============================================================================
// Module      : fc_l2_port_arbiter
// Description : Shares one L2 master port between N_REQ in-order requesters
//               with round-robin (optional core-priority) grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_l2_port_arbiter
  import fc_l2_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter bit CORE_PRIO = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  fc_l2_port_arbiter_if.master        bus,
  output logic [$clog2(MAX_OUTST):0]  outst_o,
  output logic                        spurious_o
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_mreq;
  logic             w_hs;
  logic             w_pop;
  req_t             w_reqs [N_REQ];
  req_t             w_sel;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_reqs[i].add   = bus.s_add_i[i*ADDR_W +: ADDR_W];
      w_reqs[i].wen   = bus.s_wen_i[i];
      w_reqs[i].wdata = bus.s_wdata_i[i*DATA_W +: DATA_W];
      w_reqs[i].be    = bus.s_be_i[i*BE_W +: BE_W];
    end
  end

  assign w_winner = rr_pick(bus.s_req_i, r_ptr, CORE_PRIO);
  assign w_mreq   = !rst_i && (|bus.s_req_i) && !w_full;
  assign w_hs     = w_mreq && bus.m_gnt_i;
  assign w_sel    = w_mreq ? w_reqs[w_winner] : '0;

  assign bus.m_req_o   = w_mreq;
  assign bus.m_add_o   = w_sel.add;
  assign bus.m_wen_o   = w_sel.wen;
  assign bus.m_wdata_o = w_sel.wdata;
  assign bus.m_be_o    = w_sel.be;
  assign bus.s_gnt_o   = w_hs ? (N_REQ'(1) << w_winner) : '0;

  // A response with nothing outstanding is flagged, never routed, even if a push lands this cycle.
  assign w_pop           = !rst_i && bus.m_r_valid_i && !w_empty;
  assign spurious_o      = !rst_i && bus.m_r_valid_i && w_empty;
  assign bus.s_r_valid_o = w_pop ? (N_REQ'(1) << w_head) : '0;
  assign bus.s_r_rdata_o = bus.m_r_rdata_i;
  assign bus.s_r_opc_o   = bus.m_r_opc_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_winner == IDX_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  fc_l2_arb_id_fifo #(
    .MAX_OUTST (MAX_OUTST),
    .ID_W      (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_hs),
    .i_id    (w_winner),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outst_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_fc_l2_port_arbiter.sv
// ============================================================================
// Module      : tb_fc_l2_port_arbiter
// Description : Self-checking bench driving a round-robin and a core-priority
//               arbiter instance from the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_l2_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic         t_rst;
  logic [3:0]   t_req;
  logic [127:0] t_add;
  logic [3:0]   t_wen;
  logic [127:0] t_wdata;
  logic [15:0]  t_be;
  logic         t_mgnt;
  logic         t_rvalid;
  logic [31:0]  t_rdata;
  logic         t_opc;

  logic [2:0] outst_rr, outst_pr;
  logic       spur_rr, spur_pr;

  fc_l2_port_arbiter_if bus_rr ();
  fc_l2_port_arbiter_if bus_pr ();

  assign bus_rr.s_req_i     = t_req;
  assign bus_rr.s_add_i     = t_add;
  assign bus_rr.s_wen_i     = t_wen;
  assign bus_rr.s_wdata_i   = t_wdata;
  assign bus_rr.s_be_i      = t_be;
  assign bus_rr.m_gnt_i     = t_mgnt;
  assign bus_rr.m_r_valid_i = t_rvalid;
  assign bus_rr.m_r_rdata_i = t_rdata;
  assign bus_rr.m_r_opc_i   = t_opc;
  assign bus_pr.s_req_i     = t_req;
  assign bus_pr.s_add_i     = t_add;
  assign bus_pr.s_wen_i     = t_wen;
  assign bus_pr.s_wdata_i   = t_wdata;
  assign bus_pr.s_be_i      = t_be;
  assign bus_pr.m_gnt_i     = t_mgnt;
  assign bus_pr.m_r_valid_i = t_rvalid;
  assign bus_pr.m_r_rdata_i = t_rdata;
  assign bus_pr.m_r_opc_i   = t_opc;

  fc_l2_port_arbiter #(.MAX_OUTST(4), .CORE_PRIO(1'b0)) u_dut_rr (
    .clk_i(clk), .rst_i(t_rst), .bus(bus_rr), .outst_o(outst_rr), .spurious_o(spur_rr)
  );
  fc_l2_port_arbiter #(.MAX_OUTST(4), .CORE_PRIO(1'b1)) u_dut_pr (
    .clk_i(clk), .rst_i(t_rst), .bus(bus_pr), .outst_o(outst_pr), .spurious_o(spur_pr)
  );

  // Reference model: list of outstanding requester ids plus RR pointer per instance.
  int m_ptr  [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  int m_fifo [2][4];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       g;
    logic       rv;
    logic       e_mreq;
    logic [3:0] e_gnt;
    logic [3:0] e_rv;
    logic       e_sp;
    logic [2:0] e_out;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(logic rst, logic [3:0] req, logic g, logic rv, logic e_mreq,
                              logic [3:0] e_gnt, logic [3:0] e_rv, logic e_sp, logic [2:0] e_out);
    vec_t v;
    v.rst = rst; v.req = req; v.g = g; v.rv = rv; v.e_mreq = e_mreq;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_sp = e_sp; v.e_out = e_out;
    return v;
  endfunction

  function automatic int model_pick(int ptr, logic [3:0] req, bit prio);
    if (prio && req[0]) return 0;
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return 0;
  endfunction

  task automatic cmp(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int inst);
    logic       a_mreq, a_wen, a_sp, a_opc;
    logic [3:0] a_gnt, a_rv, a_be;
    logic [31:0] a_add, a_wd, a_rd;
    logic [2:0] a_out;
    bit         prio, mreq, pop;
    int         w;
    prio = (inst == 1);
    if (inst == 0) begin
      a_mreq = bus_rr.m_req_o; a_add = bus_rr.m_add_o; a_wen = bus_rr.m_wen_o;
      a_wd = bus_rr.m_wdata_o; a_be = bus_rr.m_be_o; a_gnt = bus_rr.s_gnt_o;
      a_rv = bus_rr.s_r_valid_o; a_rd = bus_rr.s_r_rdata_o; a_opc = bus_rr.s_r_opc_o;
      a_sp = spur_rr; a_out = outst_rr;
    end else begin
      a_mreq = bus_pr.m_req_o; a_add = bus_pr.m_add_o; a_wen = bus_pr.m_wen_o;
      a_wd = bus_pr.m_wdata_o; a_be = bus_pr.m_be_o; a_gnt = bus_pr.s_gnt_o;
      a_rv = bus_pr.s_r_valid_o; a_rd = bus_pr.s_r_rdata_o; a_opc = bus_pr.s_r_opc_o;
      a_sp = spur_pr; a_out = outst_pr;
    end
    mreq = !t_rst && (|t_req) && (m_cnt[inst] < 4);
    pop  = !t_rst && t_rvalid && (m_cnt[inst] > 0);
    w    = model_pick(m_ptr[inst], t_req, prio);
    cmp("m_req", inst, 32'(a_mreq), 32'(mreq));
    cmp("m_add", inst, a_add, mreq ? t_add[w*32 +: 32] : 32'h0);
    cmp("m_wen", inst, 32'(a_wen), mreq ? 32'(t_wen[w]) : 32'h0);
    cmp("m_wdata", inst, a_wd, mreq ? t_wdata[w*32 +: 32] : 32'h0);
    cmp("m_be", inst, 32'(a_be), mreq ? 32'(t_be[w*4 +: 4]) : 32'h0);
    cmp("s_gnt", inst, 32'(a_gnt), (mreq && t_mgnt) ? (32'h1 << w) : 32'h0);
    cmp("s_r_valid", inst, 32'(a_rv), pop ? (32'h1 << m_fifo[inst][0]) : 32'h0);
    cmp("spurious", inst, 32'(a_sp), 32'(!t_rst && t_rvalid && (m_cnt[inst] == 0)));
    cmp("outst", inst, 32'(a_out), 32'(m_cnt[inst]));
    cmp("r_rdata", inst, a_rd, t_rdata);
    cmp("r_opc", inst, 32'(a_opc), 32'(t_opc));
  endtask

  task automatic update_model(input int inst);
    bit prio, mreq;
    int w;
    prio = (inst == 1);
    if (t_rst) begin
      m_cnt[inst] = 0;
      m_ptr[inst] = 0;
      return;
    end
    mreq = (|t_req) && (m_cnt[inst] < 4);
    w    = model_pick(m_ptr[inst], t_req, prio);
    if (t_rvalid && m_cnt[inst] > 0) begin
      for (int k = 0; k < 3; k++) m_fifo[inst][k] = m_fifo[inst][k+1];
      m_cnt[inst]--;
    end
    if (mreq && t_mgnt) begin
      m_fifo[inst][m_cnt[inst]] = w;
      m_cnt[inst]++;
      m_ptr[inst] = (w + 1) % 4;
    end
  endtask

  task automatic finish_cycle();
    check_inst(0);
    check_inst(1);
    update_model(0);
    update_model(1);
    @(negedge clk);
  endtask

  task automatic step();
    #2;
    finish_cycle();
  endtask

  logic [3:0] pexp [7];

  initial begin
    for (int i = 0; i < 4; i++) begin
      t_add[i*32 +: 32]   = 32'h1000_0000 + 32'(i * 16);
      t_wdata[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      t_be[i*4 +: 4]      = 4'(i + 1);
    end
    t_wen = 4'b0101;
    t_rst = 1'b1; t_req = '0; t_mgnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0; t_opc = 1'b0;
    @(negedge clk);
    @(negedge clk);

    //          rst  req     g  rv   mreq gnt     rv      sp  out
    vecs[0]  = mk(1, 4'b1111, 1, 1,  0, 4'b0000, 4'b0000, 0, 0);
    vecs[1]  = mk(0, 4'b0100, 1, 0,  1, 4'b0100, 4'b0000, 0, 0);
    vecs[2]  = mk(0, 4'b0000, 1, 1,  0, 4'b0000, 4'b0100, 0, 1);
    vecs[3]  = mk(0, 4'b0000, 1, 0,  0, 4'b0000, 4'b0000, 0, 0);
    vecs[4]  = mk(1, 4'b0000, 1, 0,  0, 4'b0000, 4'b0000, 0, 0);
    vecs[5]  = mk(0, 4'b1111, 1, 0,  1, 4'b0001, 4'b0000, 0, 0);
    vecs[6]  = mk(0, 4'b1111, 1, 1,  1, 4'b0010, 4'b0001, 0, 1);
    vecs[7]  = mk(0, 4'b1111, 1, 1,  1, 4'b0100, 4'b0010, 0, 1);
    vecs[8]  = mk(0, 4'b1111, 1, 1,  1, 4'b1000, 4'b0100, 0, 1);
    vecs[9]  = mk(0, 4'b1111, 1, 1,  1, 4'b0001, 4'b1000, 0, 1);
    vecs[10] = mk(0, 4'b0000, 1, 1,  0, 4'b0000, 4'b0001, 0, 1);
    vecs[11] = mk(0, 4'b0000, 1, 1,  0, 4'b0000, 4'b0000, 1, 0);
    vecs[12] = mk(0, 4'b0000, 1, 0,  0, 4'b0000, 4'b0000, 0, 0);
    vecs[13] = mk(0, 4'b1111, 1, 0,  1, 4'b0010, 4'b0000, 0, 0);
    vecs[14] = mk(0, 4'b1111, 1, 0,  1, 4'b0100, 4'b0000, 0, 1);
    vecs[15] = mk(0, 4'b1111, 1, 0,  1, 4'b1000, 4'b0000, 0, 2);
    vecs[16] = mk(0, 4'b1111, 1, 0,  1, 4'b0001, 4'b0000, 0, 3);
    vecs[17] = mk(0, 4'b1111, 1, 0,  0, 4'b0000, 4'b0000, 0, 4);
    vecs[18] = mk(0, 4'b1111, 1, 1,  0, 4'b0000, 4'b0010, 0, 4);
    vecs[19] = mk(0, 4'b1111, 1, 0,  1, 4'b0010, 4'b0000, 0, 3);
    vecs[20] = mk(0, 4'b1111, 1, 0,  0, 4'b0000, 4'b0000, 0, 4);
    vecs[21] = mk(0, 4'b0000, 1, 1,  0, 4'b0000, 4'b0100, 0, 4);
    vecs[22] = mk(1, 4'b1111, 1, 0,  0, 4'b0000, 4'b0000, 0, 3);
    vecs[23] = mk(0, 4'b0000, 1, 1,  0, 4'b0000, 4'b0000, 1, 0);
    vecs[24] = mk(0, 4'b1111, 1, 0,  1, 4'b0001, 4'b0000, 0, 0);
    vecs[25] = mk(0, 4'b0000, 1, 1,  0, 4'b0000, 4'b0001, 0, 1);

    for (int i = 0; i < 26; i++) begin
      t_rst = vecs[i].rst; t_req = vecs[i].req; t_mgnt = vecs[i].g; t_rvalid = vecs[i].rv;
      t_rdata = 32'hCAFE_0000 + 32'(i); t_opc = 1'(i % 2);
      #2;
      cmp($sformatf("vec%0d_m_req", i), 0, 32'(bus_rr.m_req_o), 32'(vecs[i].e_mreq));
      cmp($sformatf("vec%0d_s_gnt", i), 0, 32'(bus_rr.s_gnt_o), 32'(vecs[i].e_gnt));
      cmp($sformatf("vec%0d_s_r_valid", i), 0, 32'(bus_rr.s_r_valid_o), 32'(vecs[i].e_rv));
      cmp($sformatf("vec%0d_spurious", i), 0, 32'(spur_rr), 32'(vecs[i].e_sp));
      cmp($sformatf("vec%0d_outst", i), 0, 32'(outst_rr), 32'(vecs[i].e_out));
      finish_cycle();
    end

    // Core priority: requester 0 monopolises the port until it drops out.
    pexp[0] = 4'b0001; pexp[1] = 4'b0001; pexp[2] = 4'b0001; pexp[3] = 4'b0010;
    pexp[4] = 4'b0100; pexp[5] = 4'b1000; pexp[6] = 4'b0010;
    t_rst = 1'b1; t_req = '0; t_rvalid = 1'b0; t_mgnt = 1'b1;
    step();
    t_rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      t_req    = (c < 3) ? 4'b1111 : 4'b1110;
      t_rvalid = (c > 0);
      #2;
      cmp($sformatf("prio_gnt%0d", c), 1, 32'(bus_pr.s_gnt_o), 32'(pexp[c]));
      finish_cycle();
    end

    for (int c = 0; c < 3000; c++) begin
      t_rst    = ($urandom_range(0, 199) == 0);
      t_req    = 4'($urandom);
      t_mgnt   = ($urandom_range(0, 3) != 0);
      t_rvalid = ($urandom_range(0, 2) == 0);
      t_add    = {$urandom, $urandom, $urandom, $urandom};
      t_wdata  = {$urandom, $urandom, $urandom, $urandom};
      t_wen    = 4'($urandom);
      t_be     = 16'($urandom);
      t_rdata  = $urandom;
      t_opc    = 1'($urandom);
      step();
    end

    t_rst = 1'b0; t_req = '0; t_rvalid = 1'b1;
    for (int k = 0; k < 8 && (m_cnt[0] > 0 || m_cnt[1] > 0); k++) step();
    t_rvalid = 1'b0;
    #2;
    cmp("drain_outst", 0, 32'(outst_rr), 32'h0);
    cmp("drain_outst", 1, 32'(outst_pr), 32'h0);
    finish_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
